// File: rtl/hazard_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit_pkg
// Shared CPU definitions used by the hazard/pipeline-control block and the
// pipeline registers:
//   - hcu_state_e     : hazard FSM state encoding (IDLE=0, FPU_WAIT=1)
//   - FPU_LATENCY_MIN/MAX : legal bounds of the multi-cycle FPU latency
//   - ex_ctrl_t / EX_CTRL_BUBBLE : EX-stage control bundle and its bubble
//                                  (all-zero) value loaded on a flush
// -----------------------------------------------------------------------------
package hazard_ctrl_unit_pkg;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_FPU_WAIT = 1'b1
    } hcu_state_e;

    localparam int FPU_LATENCY_MIN = 2;
    localparam int FPU_LATENCY_MAX = 16;

    typedef struct packed {
        logic       reg_write_en;
        logic       freg_write_en;
        logic [3:0] data_mem_read;
        logic       fpu_multi;
        logic       branch_taken;
    } ex_ctrl_t;

    // A flushed pipeline register carries no side effects at all.
    localparam ex_ctrl_t EX_CTRL_BUBBLE = '{
        reg_write_en:  1'b0,
        freg_write_en: 1'b0,
        data_mem_read: 4'h0,
        fpu_multi:     1'b0,
        branch_taken:  1'b0
    };

endpackage

// File: rtl/hazard_ctrl_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that increments by one per enabled cycle and holds at all-ones.
// Ports:
//   clk      in  rising-edge clock
//   rst      in  asynchronous active-high reset (count -> 0)
//   inc_en   in  increment request for this cycle
//   count    out current count value
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] count_q;

    // Next-count: step by one unless already saturated.
    always_comb begin
        count_d = count_q;
        if (inc_en && (count_q != {WIDTH{1'b1}})) begin
            count_d = count_q + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            count_d = count_q;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= {WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// hazard_ctrl_unit
// Hazard and pipeline-control block for the 5-stage CPU. Detects load-use
// hazards, multi-cycle FPU occupancy of EX and taken branches, and drives the
// stall/flush controls of the PC, IF/ID, ID/EX and EX/MEM registers.
// Priority: RESET > branch > FPU stall > load-use.
// Ports:
//   CLK, RESET                      clock, async active-high reset
//   ID_REG_READ_ADDR1/2/3, ID_SRC_USED, ID_SRC_FREG   decode-stage sources
//   EX_REG_WRITE_ADDR/EN, EX_FREG_WRITE_EN, EX_DATA_MEM_READ,
//   EX_FPU_MULTI, EX_BRANCH_TAKEN   execute-stage control fields
//   PC_STALL, IF_ID_STALL, ID_EX_STALL        hold controls (combinational)
//   IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH    bubble controls (combinational)
//   STALL_COUNT, FLUSH_COUNT        saturating stall/flush cycle counters
// -----------------------------------------------------------------------------
module hazard_ctrl_unit
    import hazard_ctrl_unit_pkg::*;
#(
    parameter int FPU_LATENCY = 4,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [4:0]           ID_REG_READ_ADDR1,
    input  logic [4:0]           ID_REG_READ_ADDR2,
    input  logic [4:0]           ID_REG_READ_ADDR3,
    input  logic [2:0]           ID_SRC_USED,
    input  logic [2:0]           ID_SRC_FREG,
    input  logic [4:0]           EX_REG_WRITE_ADDR,
    input  logic                 EX_REG_WRITE_EN,
    input  logic                 EX_FREG_WRITE_EN,
    input  logic [3:0]           EX_DATA_MEM_READ,
    input  logic                 EX_FPU_MULTI,
    input  logic                 EX_BRANCH_TAKEN,
    output logic                 PC_STALL,
    output logic                 IF_ID_STALL,
    output logic                 ID_EX_STALL,
    output logic                 IF_ID_FLUSH,
    output logic                 ID_EX_FLUSH,
    output logic                 EX_MEM_FLUSH,
    output logic [CNT_WIDTH-1:0] STALL_COUNT,
    output logic [CNT_WIDTH-1:0] FLUSH_COUNT
);

    // FPU_LATENCY below the minimum disables FPU stalling altogether.
    localparam bit         FPU_STALL_EN = (FPU_LATENCY >= FPU_LATENCY_MIN);
    localparam logic [3:0] CNT_INIT     = FPU_STALL_EN ? 4'(FPU_LATENCY - 2) : 4'd0;

    // x0 is hardwired zero so it never hazards; f0 is a real register.
    function automatic logic src_match(
        input logic [4:0] rd_addr,
        input logic       used,
        input logic       freg,
        input logic [4:0] wr_addr,
        input logic       reg_we,
        input logic       freg_we
    );
        logic hit;
        hit = 1'b0;
        if (used && (rd_addr == wr_addr)) begin
            if (freg) begin
                hit = freg_we;
            end else begin
                hit = reg_we && (rd_addr != 5'd0);
            end
        end else begin
            hit = 1'b0;
        end
        return hit;
    endfunction

    hcu_state_e state_d, state_q;
    logic [3:0] cnt_d, cnt_q;
    logic       any_match_s;
    logic       lu_hazard_s;
    logic       fpu_stall_s;

    // Load-use detection across the three decode-stage sources.
    always_comb begin
        any_match_s = src_match(ID_REG_READ_ADDR1, ID_SRC_USED[0], ID_SRC_FREG[0],
                                EX_REG_WRITE_ADDR, EX_REG_WRITE_EN, EX_FREG_WRITE_EN)
                    | src_match(ID_REG_READ_ADDR2, ID_SRC_USED[1], ID_SRC_FREG[1],
                                EX_REG_WRITE_ADDR, EX_REG_WRITE_EN, EX_FREG_WRITE_EN)
                    | src_match(ID_REG_READ_ADDR3, ID_SRC_USED[2], ID_SRC_FREG[2],
                                EX_REG_WRITE_ADDR, EX_REG_WRITE_EN, EX_FREG_WRITE_EN);
        lu_hazard_s = (EX_DATA_MEM_READ != 4'h0) && any_match_s;
    end

    // FPU occupancy FSM: next state, down-counter and FPU stall request.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        fpu_stall_s = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // A taken branch in EX means the EX op is not an FPU op.
                if (FPU_STALL_EN && EX_FPU_MULTI && !EX_BRANCH_TAKEN) begin
                    fpu_stall_s = 1'b1;
                    cnt_d       = CNT_INIT;
                    state_d     = ST_FPU_WAIT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_FPU_WAIT: begin
                // Counter keeps advancing even if an illegal branch overrides outputs.
                if (cnt_q != 4'd0) begin
                    fpu_stall_s = 1'b1;
                    cnt_d       = cnt_q - 4'd1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Output priority resolution; everything is forced low during reset.
    always_comb begin
        PC_STALL     = 1'b0;
        IF_ID_STALL  = 1'b0;
        ID_EX_STALL  = 1'b0;
        IF_ID_FLUSH  = 1'b0;
        ID_EX_FLUSH  = 1'b0;
        EX_MEM_FLUSH = 1'b0;
        if (RESET) begin
            PC_STALL = 1'b0;
        end else if (EX_BRANCH_TAKEN) begin
            IF_ID_FLUSH = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end else if (fpu_stall_s) begin
            PC_STALL     = 1'b1;
            IF_ID_STALL  = 1'b1;
            ID_EX_STALL  = 1'b1;
            EX_MEM_FLUSH = 1'b1;
        end else if (lu_hazard_s) begin
            PC_STALL    = 1'b1;
            IF_ID_STALL = 1'b1;
            ID_EX_FLUSH = 1'b1;
        end else begin
            PC_STALL = 1'b0;
        end
    end

    // FSM state and down-counter registers.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk    (CLK),
        .rst    (RESET),
        .inc_en (PC_STALL),
        .count  (STALL_COUNT)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk    (CLK),
        .rst    (RESET),
        .inc_en (IF_ID_FLUSH),
        .count  (FLUSH_COUNT)
    );

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_ctrl_unit
// Directed bench: a table of single-cycle hazard vectors plus hand-written
// multi-cycle sequences (FPU stalls, branch priority, reset, saturation).
// A second instance with CNT_WIDTH=4 covers counter saturation.
// -----------------------------------------------------------------------------
module tb_hazard_ctrl_unit;

    logic       clk;
    logic       rst;
    logic [4:0] ra1, ra2, ra3;
    logic [2:0] used, freg;
    logic [4:0] wa;
    logic       rwe, fwe;
    logic [3:0] mrd;
    logic       fpu, br;

    logic        pc_st, ifid_st, idex_st, ifid_fl, idex_fl, exmem_fl;
    logic [15:0] stall_cnt, flush_cnt;
    logic        pc_st4, ifid_st4, idex_st4, ifid_fl4, idex_fl4, exmem_fl4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    int checks   = 0;
    int failures = 0;

    // Output bit order: {PC, IF_ID, ID_EX stall, IF_ID, ID_EX, EX_MEM flush}
    localparam logic [5:0] O_NONE = 6'b000000;
    localparam logic [5:0] O_LU   = 6'b110010;
    localparam logic [5:0] O_BR   = 6'b000110;
    localparam logic [5:0] O_FPU  = 6'b111001;

    hazard_ctrl_unit #(.FPU_LATENCY(4), .CNT_WIDTH(16)) dut (
        .CLK(clk), .RESET(rst),
        .ID_REG_READ_ADDR1(ra1), .ID_REG_READ_ADDR2(ra2), .ID_REG_READ_ADDR3(ra3),
        .ID_SRC_USED(used), .ID_SRC_FREG(freg),
        .EX_REG_WRITE_ADDR(wa), .EX_REG_WRITE_EN(rwe), .EX_FREG_WRITE_EN(fwe),
        .EX_DATA_MEM_READ(mrd), .EX_FPU_MULTI(fpu), .EX_BRANCH_TAKEN(br),
        .PC_STALL(pc_st), .IF_ID_STALL(ifid_st), .ID_EX_STALL(idex_st),
        .IF_ID_FLUSH(ifid_fl), .ID_EX_FLUSH(idex_fl), .EX_MEM_FLUSH(exmem_fl),
        .STALL_COUNT(stall_cnt), .FLUSH_COUNT(flush_cnt)
    );

    hazard_ctrl_unit #(.FPU_LATENCY(4), .CNT_WIDTH(4)) dut4 (
        .CLK(clk), .RESET(rst),
        .ID_REG_READ_ADDR1(ra1), .ID_REG_READ_ADDR2(ra2), .ID_REG_READ_ADDR3(ra3),
        .ID_SRC_USED(used), .ID_SRC_FREG(freg),
        .EX_REG_WRITE_ADDR(wa), .EX_REG_WRITE_EN(rwe), .EX_FREG_WRITE_EN(fwe),
        .EX_DATA_MEM_READ(mrd), .EX_FPU_MULTI(fpu), .EX_BRANCH_TAKEN(br),
        .PC_STALL(pc_st4), .IF_ID_STALL(ifid_st4), .ID_EX_STALL(idex_st4),
        .IF_ID_FLUSH(ifid_fl4), .ID_EX_FLUSH(idex_fl4), .EX_MEM_FLUSH(exmem_fl4),
        .STALL_COUNT(stall_cnt4), .FLUSH_COUNT(flush_cnt4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] ra1, ra2, ra3;
        logic [2:0] used, freg;
        logic [4:0] wa;
        logic       rwe, fwe;
        logic [3:0] mrd;
        logic       br;
        logic [5:0] exp;
    } vec_t;

    vec_t vecs[10];

    function automatic vec_t mk(input string n, input logic [4:0] a1, a2, a3,
                                input logic [2:0] u, f, input logic [4:0] w,
                                input logic re, fe, input logic [3:0] m,
                                input logic b, input logic [5:0] e);
        vec_t v;
        v.name = n; v.ra1 = a1; v.ra2 = a2; v.ra3 = a3; v.used = u; v.freg = f;
        v.wa = w; v.rwe = re; v.fwe = fe; v.mrd = m; v.br = b; v.exp = e;
        return v;
    endfunction

    function automatic logic [5:0] obs();
        return {pc_st, ifid_st, idex_st, ifid_fl, idex_fl, exmem_fl};
    endfunction

    function automatic logic [5:0] obs4();
        return {pc_st4, ifid_st4, idex_st4, ifid_fl4, idex_fl4, exmem_fl4};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ra1 = 5'd0; ra2 = 5'd0; ra3 = 5'd0; used = 3'b000; freg = 3'b000;
        wa = 5'd0; rwe = 1'b0; fwe = 1'b0; mrd = 4'h0; fpu = 1'b0; br = 1'b0;
    endtask

    // Canonical load-use: EX loads x5, ID source 1 reads x5.
    task automatic lu_inputs();
        idle_inputs();
        ra1 = 5'd5; used = 3'b001; wa = 5'd5; rwe = 1'b1; mrd = 4'h2;
    endtask

    // Reset spanning one rising edge; inputs change only just after edges.
    task automatic do_reset();
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Advance to the next cycle's drive point.
    task automatic next_cycle();
        @(posedge clk); #1;
    endtask

    logic [5:0] fpu_pat [8];

    initial begin
        rst = 1'b1;
        idle_inputs();
        #1;
        chk("reset_outputs", {26'd0, obs()}, {26'd0, O_NONE});
        chk("reset_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("reset_flush_cnt", {16'd0, flush_cnt}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // ---------------- table-driven single-cycle vectors ----------------
        vecs[0] = mk("lu_src1_x5",      5'd5, 5'd0, 5'd0, 3'b001, 3'b000, 5'd5, 1'b1, 1'b0, 4'h2, 1'b0, O_LU);
        vecs[1] = mk("int_ld_x0_vs_f0", 5'd0, 5'd0, 5'd0, 3'b001, 3'b001, 5'd0, 1'b1, 1'b0, 4'h2, 1'b0, O_NONE);
        vecs[2] = mk("flt_ld_f0_vs_f0", 5'd0, 5'd0, 5'd0, 3'b001, 3'b001, 5'd0, 1'b0, 1'b1, 4'h2, 1'b0, O_LU);
        vecs[3] = mk("int_x0_no_haz",   5'd0, 5'd0, 5'd0, 3'b001, 3'b000, 5'd0, 1'b1, 1'b0, 4'h2, 1'b0, O_NONE);
        vecs[4] = mk("src_unused",      5'd5, 5'd5, 5'd5, 3'b000, 3'b000, 5'd5, 1'b1, 1'b0, 4'h2, 1'b0, O_NONE);
        vecs[5] = mk("lu_src3_x7",      5'd1, 5'd2, 5'd7, 3'b100, 3'b000, 5'd7, 1'b1, 1'b0, 4'h1, 1'b0, O_LU);
        vecs[6] = mk("not_a_load",      5'd5, 5'd0, 5'd0, 3'b001, 3'b000, 5'd5, 1'b1, 1'b0, 4'h0, 1'b0, O_NONE);
        vecs[7] = mk("branch_over_lu",  5'd5, 5'd0, 5'd0, 3'b001, 3'b000, 5'd5, 1'b1, 1'b0, 4'h2, 1'b1, O_BR);
        vecs[8] = mk("file_mismatch",   5'd5, 5'd0, 5'd0, 3'b001, 3'b000, 5'd5, 1'b0, 1'b1, 4'h2, 1'b0, O_NONE);
        vecs[9] = mk("lu_src2_f9",      5'd3, 5'd9, 5'd0, 3'b011, 3'b010, 5'd9, 1'b0, 1'b1, 4'h4, 1'b0, O_LU);

        for (int i = 0; i < 10; i++) begin
            idle_inputs();
            ra1 = vecs[i].ra1; ra2 = vecs[i].ra2; ra3 = vecs[i].ra3;
            used = vecs[i].used; freg = vecs[i].freg; wa = vecs[i].wa;
            rwe = vecs[i].rwe; fwe = vecs[i].fwe; mrd = vecs[i].mrd; br = vecs[i].br;
            @(negedge clk);
            chk(vecs[i].name, {26'd0, obs()}, {26'd0, vecs[i].exp});
            next_cycle();
        end

        // ---------------- single load-use: 1-cycle stall ----------------
        do_reset();
        lu_inputs();
        @(negedge clk);
        chk("lu_seq_outputs", {26'd0, obs()}, {26'd0, O_LU});
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("lu_seq_cleared", {26'd0, obs()}, {26'd0, O_NONE});
        chk("lu_seq_stall_cnt", {16'd0, stall_cnt}, 32'd1);

        // ---------------- FPU stall, back-to-back ----------------
        fpu_pat = '{O_FPU, O_FPU, O_FPU, O_NONE, O_FPU, O_FPU, O_FPU, O_NONE};
        do_reset();
        fpu = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("fpu_cycle%0d", c + 1), {26'd0, obs()}, {26'd0, fpu_pat[c]});
            if (c == 4) chk("fpu_first_stall_cnt", {16'd0, stall_cnt}, 32'd3);
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        chk("fpu_b2b_stall_cnt", {16'd0, stall_cnt}, 32'd6);
        chk("fpu_b2b_flush_cnt", {16'd0, flush_cnt}, 32'd0);

        // ---------------- branch together with a load-use match ----------------
        do_reset();
        lu_inputs();
        br = 1'b1;
        @(negedge clk);
        chk("br_lu_outputs", {26'd0, obs()}, {26'd0, O_BR});
        next_cycle();
        idle_inputs();
        @(negedge clk);
        chk("br_lu_flush_cnt", {16'd0, flush_cnt}, 32'd1);
        chk("br_lu_stall_cnt", {16'd0, stall_cnt}, 32'd0);

        // ---------------- reset in the 2nd FPU_WAIT cycle ----------------
        do_reset();
        fpu = 1'b1;
        next_cycle();            // now in 1st FPU_WAIT cycle
        next_cycle();            // now in 2nd FPU_WAIT cycle
        @(negedge clk);
        chk("rst_mid_pre_outputs", {26'd0, obs()}, {26'd0, O_FPU});
        #1;
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs", {26'd0, obs()}, {26'd0, O_NONE});
        chk("rst_mid_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("rst_restart_cycle%0d", c + 1), {26'd0, obs()}, {26'd0, fpu_pat[c]});
            next_cycle();
        end
        idle_inputs();
        @(negedge clk);
        chk("rst_restart_stall_cnt", {16'd0, stall_cnt}, 32'd3);

        // ---------------- saturation with CNT_WIDTH=4 ----------------
        do_reset();
        lu_inputs();
        for (int c = 0; c < 20; c++) begin
            next_cycle();
        end
        @(negedge clk);
        chk("sat_outputs_w4", {26'd0, obs4()}, {26'd0, O_LU});
        chk("sat_stall_cnt_w4", {28'd0, stall_cnt4}, 32'hF);
        chk("sat_stall_cnt_w16", {16'd0, stall_cnt}, 32'd20);
        chk("sat_flush_cnt_w4", {28'd0, flush_cnt4}, 32'd0);
        idle_inputs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_unit.md
# hazard_ctrl_unit

Hazard and pipeline-control block for the 5-stage CPU. It reads the execute-stage control fields held by the ID/EX pipeline register and the decode-stage source operands. It drives the stall and flush controls back into the PC, IF/ID, ID/EX and EX/MEM registers for three cases: load-use hazards, multi-cycle FPU operations and taken branches. It also keeps saturating performance counters of stall and flush cycles.

## Interface
- FPU_LATENCY, default 4: total cycles a multi-cycle FPU op occupies EX. Legal range is 2..16; value 1 disables FPU stalling.
- CNT_WIDTH, default 16: width of the performance counters.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  asynchronous, active-high reset.
- ID_REG_READ_ADDR1/2/3  in  5 each  decode-stage source register addresses.
- ID_SRC_USED  in  3  bit i=1 means source i+1 is read by the ID instruction.
- ID_SRC_FREG  in  3  bit i=1 means source i+1 is a float register.
- EX_REG_WRITE_ADDR  in  5  destination of the EX instruction.
- EX_REG_WRITE_EN  in  1  EX instruction writes the integer file.
- EX_FREG_WRITE_EN  in  1  EX instruction writes the float file.
- EX_DATA_MEM_READ  in  4  nonzero means the EX instruction is a load.
- EX_FPU_MULTI  in  1  EX instruction is a multi-cycle FPU op.
- EX_BRANCH_TAKEN  in  1  resolved taken branch or jump in EX.
- PC_STALL, IF_ID_STALL, ID_EX_STALL  out  1 each  hold the register.
- IF_ID_FLUSH, ID_EX_FLUSH, EX_MEM_FLUSH  out  1 each  load a bubble (all-zero controls).
- STALL_COUNT  out  CNT_WIDTH  cycles with PC_STALL=1, saturating.
- FLUSH_COUNT  out  CNT_WIDTH  cycles with IF_ID_FLUSH=1, saturating.

## Operation
- **Source match (load-use):** hazard for source i when all hold:
  - ID_SRC_USED[i]=1;
  - the address equals EX_REG_WRITE_ADDR;
  - either ID_SRC_FREG[i]=1 and EX_FREG_WRITE_EN=1, or ID_SRC_FREG[i]=0, EX_REG_WRITE_EN=1 and the address is nonzero (x0 never hazards; f0 does).
- **Load-use (LU):** EX_DATA_MEM_READ≠0 and any source matches.
  - Response: PC_STALL=IF_ID_STALL=1, ID_EX_FLUSH=1.
  - The condition clears the next cycle as the load advances, so LU lasts exactly 1 cycle.
- **FSM states:** IDLE and FPU_WAIT, with a 4-bit down-counter CNT.
  - IDLE with EX_FPU_MULTI=1 (and FPU_LATENCY≥2):
    - assert PC_STALL, IF_ID_STALL, ID_EX_STALL, EX_MEM_FLUSH;
    - CNT←FPU_LATENCY−2; go to FPU_WAIT.
  - FPU_WAIT with CNT≠0: same four outputs asserted; CNT←CNT−1.
  - FPU_WAIT with CNT=0: no FPU outputs; go to IDLE. The op leaves EX on this edge.
  - Net effect: FPU_LATENCY−1 stall cycles; the op spends FPU_LATENCY cycles in EX.
  - Back-to-back FPU ops are each handled from IDLE.
- **Branch:** EX_BRANCH_TAKEN=1 gives IF_ID_FLUSH=ID_EX_FLUSH=1 and all stalls 0 for 1 cycle.
- **Priority:** RESET > branch > FPU stall > LU.
  - A branch suppresses a coincident LU, since the ID instruction is discarded.
  - LU evaluation is masked while FPU stall outputs are asserted.
- **Counters:** each increments by 1 per qualifying cycle and holds at all-ones.

## Timing
- Stall and flush outputs are combinational from state, CNT and inputs, valid in the same cycle. No added latency.
- State, CNT and counters update on the CLK rising edge.
- RESET=1 acts asynchronously:
  - state=IDLE, CNT=0, STALL_COUNT=0, FLUSH_COUNT=0;
  - all six stall/flush outputs are forced to 0 while RESET is high, including mid-FPU_WAIT.
- First edge after RESET deasserts: normal evaluation from IDLE.
- EX_FPU_MULTI is sampled only in IDLE. Changes to it during FPU_WAIT are ignored.
- EX_BRANCH_TAKEN during FPU_WAIT cannot occur legally. If it does, branch outputs win for that cycle and the counter still advances.

## Structure
- **Shared cpu package:** FSM state encoding (IDLE=0, FPU_WAIT=1), FPU_LATENCY legal bounds, and the bubble (all-zero) control constant used by the pipeline registers.
- **Sub-module sat_counter:** parameterized width, increment enable, async reset, holds at max. Instantiated twice.
- The match logic is a combinational function inside the block.

## Test plan
- EX load to x5 (EX_DATA_MEM_READ=4'h2, EX_REG_WRITE_EN=1), ID source 1 = x5 used -> PC_STALL=IF_ID_STALL=ID_EX_FLUSH=1 for 1 cycle; STALL_COUNT=1.
- Two cases against a float source f0:
  - EX integer load to x0 -> no stall;
  - EX float load to f0 -> 1-cycle stall.
- FPU_LATENCY=4, EX_FPU_MULTI=1 from IDLE -> 3 cycles of PC/IF_ID/ID_EX stall plus EX_MEM_FLUSH, release on the 4th cycle; STALL_COUNT=3. Repeat back-to-back -> 6.
- EX_BRANCH_TAKEN=1 together with a valid LU match -> IF_ID_FLUSH=ID_EX_FLUSH=1, no stalls; FLUSH_COUNT=1, STALL_COUNT=0.
- RESET pulsed in the 2nd FPU_WAIT cycle -> outputs 0 immediately, counters 0. After release with EX_FPU_MULTI=1 -> a full new 3-cycle stall.
- CNT_WIDTH=4 with 20 consecutive LU cycles -> STALL_COUNT holds 4'hF.
